// File: rtl/mandelbrot_dispatcher.sv
// Round-robin front end for NUM_ENGINES mandelbrotetron instances.
// Issues coordinates to engines in turn and returns results strictly in acceptance order.
module mandelbrot_dispatcher #(
  parameter int COORD_WIDTH = 32,
  parameter int ITER_WIDTH  = 8,
  parameter int NUM_ENGINES = 4
) (
  input  logic                               clk,
  input  logic                               nrst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [COORD_WIDTH-1:0]             in_c_real,
  input  logic [COORD_WIDTH-1:0]             in_c_imag,
  output logic [NUM_ENGINES-1:0]             eng_start,
  output logic [NUM_ENGINES*COORD_WIDTH-1:0] eng_c_real,
  output logic [NUM_ENGINES*COORD_WIDTH-1:0] eng_c_imag,
  input  logic [NUM_ENGINES-1:0]             eng_valid,
  input  logic [NUM_ENGINES-1:0]             eng_is_mandelbrot,
  input  logic [NUM_ENGINES*ITER_WIDTH-1:0]  eng_iterations,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               out_is_mandelbrot,
  output logic [ITER_WIDTH-1:0]              out_iterations,
  output logic                               busy,
  output logic                               proto_err
);

  localparam int PTR_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  logic [1:0]                       state_r [NUM_ENGINES];
  logic [1:0]                       state_nx_s [NUM_ENGINES];
  logic [PTR_W-1:0]                 issue_ptr_r;
  logic [PTR_W-1:0]                 ret_ptr_r;
  logic [NUM_ENGINES-1:0]           res_mand_r;
  logic [ITER_WIDTH-1:0]            res_iter_r [NUM_ENGINES];
  logic [NUM_ENGINES-1:0]           eng_start_r;
  logic [NUM_ENGINES*COORD_WIDTH-1:0] c_real_r;
  logic [NUM_ENGINES*COORD_WIDTH-1:0] c_imag_r;
  logic                             proto_err_r;

  logic                             in_ready_s;
  logic                             out_valid_s;
  logic                             busy_s;
  logic                             accept_s;
  logic                             retire_s;
  logic [NUM_ENGINES-1:0]           start_nx_s;
  logic [NUM_ENGINES-1:0]           cap_s;
  logic [NUM_ENGINES-1:0]           err_s;

  // Pointers wrap naturally because NUM_ENGINES is a power of two; one slot pins them at zero.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] r;
    if (NUM_ENGINES == 1) begin
      r = {PTR_W{1'b0}};
    end else begin
      r = p + PTR_W'(1'b1);
    end
    return r;
  endfunction

  // Handshake and status decode, from registered state only.
  always_comb begin
    in_ready_s  = (state_r[issue_ptr_r] == ST_IDLE);
    out_valid_s = (state_r[ret_ptr_r] == ST_DONE);
    accept_s    = in_valid && in_ready_s;
    retire_s    = out_valid_s && out_ready;
    busy_s      = 1'b0;
    for (int i = 0; i < NUM_ENGINES; i++) begin
      busy_s = busy_s | (state_r[i] != ST_IDLE);
    end
  end

  // Per-slot next state, result capture strobe, start pulse and protocol-error detection.
  always_comb begin
    for (int i = 0; i < NUM_ENGINES; i++) begin
      state_nx_s[i] = state_r[i];
      cap_s[i]      = 1'b0;
      start_nx_s[i] = accept_s && (issue_ptr_r == PTR_W'(i));
      err_s[i]      = eng_valid[i] && (state_r[i] != ST_RUN);
      case (state_r[i])
        ST_IDLE: begin
          if (start_nx_s[i]) begin
            state_nx_s[i] = ST_RUN;
          end else begin
            state_nx_s[i] = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (eng_valid[i]) begin
            state_nx_s[i] = ST_DONE;
            cap_s[i]      = 1'b1;
          end else begin
            state_nx_s[i] = ST_RUN;
          end
        end
        ST_DONE: begin
          if (retire_s && (ret_ptr_r == PTR_W'(i))) begin
            state_nx_s[i] = ST_IDLE;
          end else begin
            state_nx_s[i] = ST_DONE;
          end
        end
        default: begin
          state_nx_s[i] = ST_IDLE;
        end
      endcase
    end
  end

  // Slot state machines and captured engine results.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < NUM_ENGINES; i++) begin
        state_r[i]    <= ST_IDLE;
        res_iter_r[i] <= {ITER_WIDTH{1'b0}};
      end
      res_mand_r <= {NUM_ENGINES{1'b0}};
    end else begin
      for (int i = 0; i < NUM_ENGINES; i++) begin
        state_r[i] <= state_nx_s[i];
        if (cap_s[i]) begin
          res_mand_r[i] <= eng_is_mandelbrot[i];
          res_iter_r[i] <= eng_iterations[i*ITER_WIDTH +: ITER_WIDTH];
        end
      end
    end
  end

  // Coordinate fields hold until the next accept into the same slot; start is a one-cycle pulse.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      c_real_r    <= {(NUM_ENGINES*COORD_WIDTH){1'b0}};
      c_imag_r    <= {(NUM_ENGINES*COORD_WIDTH){1'b0}};
      eng_start_r <= {NUM_ENGINES{1'b0}};
    end else begin
      for (int i = 0; i < NUM_ENGINES; i++) begin
        if (start_nx_s[i]) begin
          c_real_r[i*COORD_WIDTH +: COORD_WIDTH] <= in_c_real;
          c_imag_r[i*COORD_WIDTH +: COORD_WIDTH] <= in_c_imag;
        end
      end
      eng_start_r <= start_nx_s;
    end
  end

  // Issue/return pointers and the sticky protocol-error flag.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      issue_ptr_r <= {PTR_W{1'b0}};
      ret_ptr_r   <= {PTR_W{1'b0}};
      proto_err_r <= 1'b0;
    end else begin
      if (accept_s) begin
        issue_ptr_r <= ptr_inc(issue_ptr_r);
      end
      if (retire_s) begin
        ret_ptr_r <= ptr_inc(ret_ptr_r);
      end
      proto_err_r <= proto_err_r | (|err_s);
    end
  end

  assign in_ready          = in_ready_s;
  assign out_valid         = out_valid_s;
  assign busy              = busy_s;
  assign eng_start         = eng_start_r;
  assign eng_c_real        = c_real_r;
  assign eng_c_imag        = c_imag_r;
  assign out_is_mandelbrot = res_mand_r[ret_ptr_r];
  assign out_iterations    = res_iter_r[ret_ptr_r];
  assign proto_err         = proto_err_r;

endmodule

// File: tb/tb_mandelbrot_dispatcher.sv
// Self-checking bench for mandelbrot_dispatcher: directed scenarios plus randomized traffic
// against a pixel-level model (in-flight count, per-pixel done flags, results in acceptance order).
module tb_mandelbrot_dispatcher;
  localparam int CW   = 32;
  localparam int IW   = 8;
  localparam int N    = 4;
  localparam int MAXP = 4096;
  localparam int RVW  = N + 2*N*CW + IW + 5;

  logic clk = 1'b0;
  logic nrst;
  logic in_valid;
  logic in_ready;
  logic [CW-1:0] in_c_real, in_c_imag;
  logic [N-1:0] eng_start;
  logic [N*CW-1:0] eng_c_real, eng_c_imag;
  logic [N-1:0] eng_valid, eng_is_mandelbrot;
  logic [N*IW-1:0] eng_iterations;
  logic out_valid, out_ready, out_is_mandelbrot;
  logic [IW-1:0] out_iterations;
  logic busy, proto_err;

  always #5 clk = ~clk;

  mandelbrot_dispatcher #(.COORD_WIDTH(CW), .ITER_WIDTH(IW), .NUM_ENGINES(N)) dut (
    .clk(clk), .nrst(nrst),
    .in_valid(in_valid), .in_ready(in_ready), .in_c_real(in_c_real), .in_c_imag(in_c_imag),
    .eng_start(eng_start), .eng_c_real(eng_c_real), .eng_c_imag(eng_c_imag),
    .eng_valid(eng_valid), .eng_is_mandelbrot(eng_is_mandelbrot), .eng_iterations(eng_iterations),
    .out_valid(out_valid), .out_ready(out_ready), .out_is_mandelbrot(out_is_mandelbrot),
    .out_iterations(out_iterations), .busy(busy), .proto_err(proto_err)
  );

  int checks;
  int errors;

  // Reference model: pixels numbered in acceptance order.
  int acc, ret;
  logic [IW-1:0] exp_iter [MAXP];
  logic          exp_mand [MAXP];
  logic [CW-1:0] exp_cr [MAXP];
  logic [CW-1:0] exp_ci [MAXP];
  bit            done_q [MAXP];
  logic [N-1:0]  exp_start;
  // Engine models
  int eng_pid [N];
  int eng_cd [N];
  bit use_forced;
  int forced_lat [N];
  logic [IW-1:0] forced_iter [N];
  logic forced_mand [N];
  int lat_max;
  logic [N-1:0] inj_valid;

  task automatic model_reset();
    acc = 0;
    ret = 0;
    exp_start = '0;
    for (int i = 0; i < N; i++) eng_cd[i] = 0;
    eng_valid = '0;
  endtask

  // One clock cycle: engines fire, the edge happens, the model advances.
  task automatic tick();
    bit will_acc, will_ret;
    logic [N-1:0] fired;
    int p, s, lat;
    will_acc = (in_valid === 1'b1) && ((acc - ret) < N);
    will_ret = (out_ready === 1'b1) && (acc > ret) && done_q[ret % MAXP];
    fired = '0;
    for (int i = 0; i < N; i++) begin
      if (eng_cd[i] > 0) begin
        eng_cd[i]--;
        if (eng_cd[i] == 0) begin
          fired[i] = 1'b1;
          p = eng_pid[i] % MAXP;
          eng_is_mandelbrot[i] = exp_mand[p];
          eng_iterations[i*IW +: IW] = exp_iter[p];
        end
      end
    end
    eng_valid = fired | inj_valid;
    @(posedge clk);
    #1;
    eng_valid = '0;
    for (int i = 0; i < N; i++) if (fired[i]) done_q[eng_pid[i] % MAXP] = 1'b1;
    if (will_ret) ret++;
    exp_start = '0;
    if (will_acc) begin
      p = acc % MAXP;
      s = acc % N;
      exp_cr[p] = in_c_real;
      exp_ci[p] = in_c_imag;
      done_q[p] = 1'b0;
      exp_start[s] = 1'b1;
      eng_pid[s] = acc;
      lat = use_forced ? forced_lat[s] : $urandom_range(1, lat_max);
      eng_cd[s] = lat + 1;
      exp_iter[p] = use_forced ? forced_iter[s] : IW'($urandom);
      exp_mand[p] = use_forced ? forced_mand[s] : 1'($urandom);
      acc++;
    end
  endtask

  task automatic apply_reset();
    nrst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    inj_valid = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    nrst = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    logic [RVW-1:0] got, expv;
    expv = {1'b1, {N{1'b0}}, {(2*N*CW){1'b0}}, 1'b0, 1'b0, {IW{1'b0}}, 1'b0, 1'b0};
    nrst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    eng_valid = '0;
    #1;
    for (int k = 0; k < 2; k++) begin
      got = {in_ready, eng_start, eng_c_real, eng_c_imag, out_valid, out_is_mandelbrot,
             out_iterations, busy, proto_err};
      checks++;
      if (got !== expv) begin
        errors++;
        $display("FAIL reset_values step %0d got %h exp %h", k, got, expv);
      end
      repeat (3) @(posedge clk);
      #1;
    end
    nrst = 1'b1;
    model_reset();
  endtask

  task automatic test_single_pixel();
    apply_reset();
    use_forced = 1'b1;
    forced_lat[0] = 10;
    forced_iter[0] = 8'h2A;
    forced_mand[0] = 1'b0;
    in_valid = 1'b1;
    in_c_real = 32'h0001_0000;
    in_c_imag = 32'h0002_0000;
    tick();
    in_valid = 1'b0;
    checks++;
    if ({eng_start, eng_c_real[CW-1:0], eng_c_imag[CW-1:0]} !== {4'b0001, 32'h0001_0000, 32'h0002_0000}) begin
      errors++;
      $display("FAIL single_start got start=%b cr=%h ci=%h exp 0001 00010000 00020000",
               eng_start, eng_c_real[CW-1:0], eng_c_imag[CW-1:0]);
    end
    for (int k = 1; k <= 11; k++) begin
      tick();
      checks++;
      if (k < 11) begin
        if ({out_valid, eng_start} !== {1'b0, 4'b0000}) begin
          errors++;
          $display("FAIL single_wait cycle %0d got out_valid=%b start=%b exp 0 0000", k, out_valid, eng_start);
        end
      end else begin
        if ({out_valid, out_is_mandelbrot, out_iterations} !== {1'b1, 1'b0, 8'h2A}) begin
          errors++;
          $display("FAIL single_result got v=%b m=%b it=%h exp 1 0 2a", out_valid, out_is_mandelbrot, out_iterations);
        end
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      errors++;
      $display("FAIL single_retire got v=%b busy=%b rdy=%b exp 0 0 1", out_valid, busy, in_ready);
    end
  endtask

  task automatic test_out_of_order();
    logic [IW-1:0] got [4];
    int n;
    apply_reset();
    use_forced = 1'b1;
    forced_lat[0] = 12; forced_lat[1] = 9; forced_lat[2] = 12; forced_lat[3] = 5;
    for (int i = 0; i < N; i++) begin
      forced_iter[i] = IW'(i + 1);
      forced_mand[i] = 1'(i);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_c_real = $urandom;
      in_c_imag = $urandom;
      tick();
    end
    in_valid = 1'b0;
    n = 0;
    for (int k = 0; k < 40 && n < 4; k++) begin
      tick();
      checks++;
      if (!done_q[0] && out_valid !== 1'b0) begin
        errors++;
        $display("FAIL ooo_hold cycle %0d got out_valid=%b exp 0 before engine 0 done", k, out_valid);
      end
      if (out_valid === 1'b1) begin
        got[n] = out_iterations;
        n++;
      end
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL ooo_count got %0d results exp 4", n);
    end
    for (int j = 0; j < n; j++) begin
      checks++;
      if (got[j] !== IW'(j + 1)) begin
        errors++;
        $display("FAIL ooo_order index %0d got %0d exp %0d", j, got[j], j + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [IW-1:0] held;
    int base;
    apply_reset();
    use_forced = 1'b0;
    lat_max = 6;
    out_ready = 1'b0;
    base = acc;
    for (int k = 0; k < 20 && acc < base + 4; k++) begin
      in_valid = 1'b1;
      in_c_real = $urandom;
      in_c_imag = $urandom;
      tick();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 30 && !(done_q[base] && done_q[base+1] && done_q[base+2] && done_q[base+3]); k++) tick();
    held = exp_iter[base];
    in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++;
      if ({in_ready, out_valid, out_iterations, out_is_mandelbrot} !== {1'b0, 1'b1, held, exp_mand[base]}) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got rdy=%b v=%b it=%h m=%b exp 0 1 %h %b",
                 k, in_ready, out_valid, out_iterations, out_is_mandelbrot, held, exp_mand[base]);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if ({in_ready, out_valid, out_iterations} !== {1'b1, 1'b1, exp_iter[base+1]}) begin
      errors++;
      $display("FAIL bp_release got rdy=%b v=%b it=%h exp 1 1 %h", in_ready, out_valid, out_iterations, exp_iter[base+1]);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 20 && acc != ret; k++) tick();
    out_ready = 1'b0;
    checks++;
    if ({busy, out_valid} !== 2'b00) begin
      errors++;
      $display("FAIL bp_drain got busy=%b v=%b exp 0 0", busy, out_valid);
    end
  endtask

  task automatic test_proto_err();
    checks++;
    if ({proto_err, busy} !== 2'b00) begin
      errors++;
      $display("FAIL perr_pre got perr=%b busy=%b exp 0 0", proto_err, busy);
    end
    inj_valid = 4'b0100;
    tick();
    inj_valid = '0;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if ({proto_err, out_valid, busy} !== 3'b100) begin
        errors++;
        $display("FAIL perr_sticky cycle %0d got perr=%b v=%b busy=%b exp 1 0 0", k, proto_err, out_valid, busy);
      end
      tick();
    end
  endtask

  task automatic test_reset_midflight();
    logic [RVW-1:0] got, expv;
    logic [CW-1:0] cr;
    expv = {1'b1, {N{1'b0}}, {(2*N*CW){1'b0}}, 1'b0, 1'b0, {IW{1'b0}}, 1'b0, 1'b0};
    use_forced = 1'b1;
    for (int i = 0; i < N; i++) forced_lat[i] = 30;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_c_real = $urandom | 32'h1;
      in_c_imag = $urandom;
      tick();
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if ({busy, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL midrst_pre got busy=%b v=%b exp 1 0", busy, out_valid);
    end
    nrst = 1'b0;
    #1;
    got = {in_ready, eng_start, eng_c_real, eng_c_imag, out_valid, out_is_mandelbrot,
           out_iterations, busy, proto_err};
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL midrst_values got %h exp %h", got, expv);
    end
    @(posedge clk); #1;
    nrst = 1'b1;
    model_reset();
    use_forced = 1'b0;
    lat_max = 4;
    cr = $urandom;
    in_valid = 1'b1;
    in_c_real = cr;
    in_c_imag = $urandom;
    tick();
    in_valid = 1'b0;
    checks++;
    if ({eng_start, eng_c_real[CW-1:0]} !== {4'b0001, cr}) begin
      errors++;
      $display("FAIL midrst_reissue got start=%b cr=%h exp 0001 %h", eng_start, eng_c_real[CW-1:0], cr);
    end
    for (int k = 0; k < 20 && acc != ret; k++) tick();
    out_ready = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_drain got busy=%b exp 0", busy);
    end
  endtask

  task automatic test_random();
    int pin, pout, s, p;
    apply_reset();
    use_forced = 1'b0;
    for (int ph = 0; ph < 3; ph++) begin
      lat_max = (ph == 0) ? 1 : (ph == 1) ? 6 : 20;
      pin  = (ph == 2) ? 50 : 85;
      pout = (ph == 1) ? 40 : 90;
      for (int c = 0; c < 500; c++) begin
        in_valid  = ($urandom_range(0, 99) < pin);
        in_c_real = $urandom;
        in_c_imag = $urandom;
        out_ready = ($urandom_range(0, 99) < pout);
        tick();
        checks++;
        if ({in_ready, out_valid, busy} !== {((acc - ret) < N), ((acc > ret) && done_q[ret % MAXP]), (acc != ret)}) begin
          errors++;
          $display("FAIL rand_flags cycle %0d got rdy=%b v=%b busy=%b inflight=%0d", c, in_ready, out_valid, busy, acc - ret);
        end
        checks++;
        if (eng_start !== exp_start) begin
          errors++;
          $display("FAIL rand_start cycle %0d got %b exp %b", c, eng_start, exp_start);
        end
        if (exp_start != '0) begin
          s = (acc - 1) % N;
          p = (acc - 1) % MAXP;
          checks++;
          if ({eng_c_real[s*CW +: CW], eng_c_imag[s*CW +: CW]} !== {exp_cr[p], exp_ci[p]}) begin
            errors++;
            $display("FAIL rand_coord slot %0d got %h %h exp %h %h", s, eng_c_real[s*CW +: CW], eng_c_imag[s*CW +: CW], exp_cr[p], exp_ci[p]);
          end
        end
        if ((acc > ret) && done_q[ret % MAXP]) begin
          p = ret % MAXP;
          checks++;
          if ({out_is_mandelbrot, out_iterations} !== {exp_mand[p], exp_iter[p]}) begin
            errors++;
            $display("FAIL rand_result pixel %0d got m=%b it=%h exp m=%b it=%h", ret, out_is_mandelbrot, out_iterations, exp_mand[p], exp_iter[p]);
          end
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 200 && acc != ret; k++) tick();
    checks++;
    if ({busy, out_valid, in_ready} !== 3'b001) begin
      errors++;
      $display("FAIL rand_drain got busy=%b v=%b rdy=%b exp 0 0 1", busy, out_valid, in_ready);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    in_valid = 1'b0;
    in_c_real = '0;
    in_c_imag = '0;
    out_ready = 1'b0;
    eng_valid = '0;
    eng_is_mandelbrot = '0;
    eng_iterations = '0;
    inj_valid = '0;
    use_forced = 1'b0;
    lat_max = 8;
    model_reset();
    test_reset();
    test_single_pixel();
    test_out_of_order();
    test_backpressure();
    test_proto_err();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
